display_scan_driver: RTL and testbench

Upstream driver for the BCD-to-7-segment decoder. Accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto a 4-digit common-anode display. Each scan slot presents one BCD nibble on `digit`, which feeds the decoder's `number` input, and drives the matching active-low anode enable.

---
 rtl/display_scan_driver.sv | 109 ++++++++++
 tb/tb_display_scan_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - binary to BCD converter with 4-digit multiplexed display scan
// Sequential double-dabble conversion feeding a common-anode scan with leading-zero blanking.
module display_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [13:0] value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic [3:0]  digit_o,
  output logic [3:0]  anode_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    iter_q, iter_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   adj;
  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    scan_q, scan_d;
  logic          blank;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      iter_q    <= 4'd0;
      bin_q     <= 14'd0;
      scratch_q <= 16'd0;
      bcd_q     <= 16'd0;
      ref_cnt_q <= '0;
      scan_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      ref_cnt_q <= ref_cnt_d;
      scan_q    <= scan_d;
    end
  end

  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < 4; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d   = S_CONV;
          iter_d    = 4'd0;
          scratch_d = 16'd0;
          // Saturating here keeps every scratch nibble a legal BCD digit.
          bin_d     = (value_i > 14'd9999) ? 14'd9999 : value_i;
        end
      end
      S_CONV: begin
        scratch_d = {adj[14:0], bin_q[13]};
        bin_d     = {bin_q[12:0], 1'b0};
        iter_d    = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          state_d = S_IDLE;
          bcd_d   = {adj[14:0], bin_q[13]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + CW'(1);
    scan_d    = scan_q;
    if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d = '0;
      scan_d    = scan_q + 2'd1;
    end
  end

  always_comb begin
    case (scan_q)
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  assign busy_o  = (state_q == S_CONV);
  assign digit_o = bcd_q[4*scan_q +: 4];
  assign anode_o = (BLANK_LEADING && blank) ? 4'b1111 : ~(4'b0001 << scan_q);

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - self-checking bench for display_scan_driver
// Two instances (blanking on/off) share stimulus; expectations come from decimal arithmetic.
module tb_display_scan_driver;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        busy1, busy0;
  logic [3:0]  digit1, digit0;
  logic [3:0]  anode1, anode0;

  int          errors = 0;
  int          checks = 0;
  int          cyc;
  logic [15:0] model_bcd;

  display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load),
    .busy_o(busy1), .digit_o(digit1), .anode_o(anode1)
  );

  display_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load),
    .busy_o(busy0), .digit_o(digit0), .anode_o(anode0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; the scan slot follows directly from this count.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [15:0] exp_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] exp_digit(input logic [15:0] b, input int slot);
    logic [15:0] sh;
    sh = b >> (4 * slot);
    return sh[3:0];
  endfunction

  function automatic logic [3:0] exp_anode(input logic [15:0] b, input int slot, input bit blank);
    logic [3:0]  a;
    logic [15:0] upper;
    upper = b >> (4 * slot);
    if (blank && slot > 0 && upper == 16'd0) return 4'b1111;
    a = 4'b1111;
    a[slot] = 1'b0;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag);
    int slot;
    slot = (cyc / 4) % 4;
    chk({tag, "_digit_b1"}, 32'(digit1), 32'(exp_digit(model_bcd, slot)));
    chk({tag, "_anode_b1"}, 32'(anode1), 32'(exp_anode(model_bcd, slot, 1'b1)));
    chk({tag, "_digit_b0"}, 32'(digit0), 32'(exp_digit(model_bcd, slot)));
    chk({tag, "_anode_b0"}, 32'(anode0), 32'(exp_anode(model_bcd, slot, 1'b0)));
  endtask

  task automatic check_frame(input string tag);
    repeat (16) begin
      @(negedge clk);
      check_disp(tag);
    end
  endtask

  // inject=1 re-strobes load with 77 so that it is sampled at E5.
  task automatic do_conv(input int v, input bit inject);
    int n;
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("busy_rise", 32'(busy1), 32'd1);
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      check_disp("disp_hold");
      @(negedge clk);
      n++;
      if (inject && n == 4) begin value = 14'd77; load = 1'b1; end
      if (inject && n == 5) load = 1'b0;
    end
    chk("busy_len", 32'(n), 32'd14);
    chk("busy_b0", 32'(busy0), 32'd0);
    model_bcd = exp_bcd(v);
    chk("bcd_reg", 32'(u_dut.bcd_q), 32'(model_bcd));
    check_disp("disp_new");
  endtask

  initial begin
    rst       = 1'b0;
    value     = 14'd0;
    load      = 1'b0;
    model_bcd = 16'd0;

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode1), 32'b1110);
    chk("rst_digit", 32'(digit1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_frame("rst_frame");

    do_conv(1234, 1'b0);  check_frame("f1234");
    do_conv(16383, 1'b0);
    do_conv(9999, 1'b0);  check_frame("f9999");
    do_conv(0, 1'b0);     check_frame("f0");
    do_conv(105, 1'b0);   check_frame("f105");
    do_conv(1000, 1'b0);  check_frame("f1000");
    do_conv(7, 1'b0);     check_frame("f7");

    do_conv(42, 1'b1);
    chk("busy_ignore", 32'(u_dut.bcd_q), 32'h0042);
    do_conv(77, 1'b0);

    @(negedge clk);
    value = 14'd5678;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_bcd = 16'd0;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_bcd", 32'(u_dut.bcd_q), 32'd0);
    chk("midrst_anode", 32'(anode1), 32'b1110);
    chk("midrst_digit", 32'(digit1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_frame("midrst_frame");
    do_conv(31, 1'b0);    check_frame("f31");

    for (int i = 0; i < 6; i++) begin
      do_conv(int'($urandom_range(0, 16383)), 1'b0);
      check_frame("frand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
